// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, exception type encodings,
// reset and constant register values.
package cp0_reg_pkg;

    typedef enum logic [4:0] {
        REG_BADVADDR = 5'd8,
        REG_COUNT    = 5'd9,
        REG_COMPARE  = 5'd11,
        REG_STATUS   = 5'd12,
        REG_CAUSE    = 5'd13,
        REG_EPC      = 5'd14,
        REG_PRID     = 5'd15,
        REG_CONFIG   = 5'd16
    } cp0_addr_e;

    typedef enum logic [31:0] {
        EXC_INT  = 32'h0000_0001,
        EXC_ADEL = 32'h0000_0004,
        EXC_ADES = 32'h0000_0005,
        EXC_SYS  = 32'h0000_0008,
        EXC_BP   = 32'h0000_0009,
        EXC_RI   = 32'h0000_000a,
        EXC_OV   = 32'h0000_000c,
        EXC_ERET = 32'h0000_000e
    } exc_type_e;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam logic [31:0] PRID_VAL   = 32'h0000_4220;
    localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

    // Interrupts report ExcCode 0; every other type maps onto its low five bits.
    function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
        return (exc_type == EXC_INT) ? 5'd0 : exc_type[4:0];
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// MTC0/MFC0 register bus plus the exception-commit signals from the M stage.
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        is_except_i;
    logic [31:0] except_type_i;
    logic [31:0] current_pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i,
        output is_except_i, except_type_i, current_pc_i, is_in_delayslot_i, bad_addr_i,
        input  rdata_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i,
        input  is_except_i, except_type_i, current_pc_i, is_in_delayslot_i, bad_addr_i,
        output rdata_o
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on match
// and is released only by rewriting Compare.
module cp0_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick      <= 1'b0;
            count_o   <= 32'd0;
            compare_o <= 32'd0;
            ti_o      <= 1'b0;
        end else begin
            tick <= ~tick;
            if (wr_en && waddr == REG_COUNT)
                count_o <= wdata;
            else if (tick)
                count_o <= count_o + 32'd1;
            // A Compare write clears TI even if the old values happen to match.
            if (wr_en && waddr == REG_COMPARE) begin
                compare_o <= wdata;
                ti_o      <= 1'b0;
            end else if (count_o == compare_o) begin
                ti_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor 0 register file: Status/Cause/EPC/BadVAddr, exception and ERET
// updates, MFC0 read mux, with the timer split out into cp0_timer.
module cp0_reg
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int,
    cp0_reg_if.slave    bus,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [31:0] status_q;
    logic        cause_bd;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        wr_en;
    logic        is_eret;
    logic        take_exc;

    // An exception in the same cycle fully suppresses the MTC0.
    assign wr_en    = bus.we_i & ~bus.is_except_i;
    assign is_eret  = bus.is_except_i && (bus.except_type_i == EXC_ERET);
    assign take_exc = bus.is_except_i && !is_eret;

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .waddr     (bus.waddr_i),
        .wdata     (bus.wdata_i),
        .count_o   (count),
        .compare_o (compare),
        .ti_o      (ti)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_bd   <= 1'b0;
            cause_ip   <= 8'd0;
            cause_exc  <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            cause_ip[7:2] <= {ext_int[5] | ti, ext_int[4:0]};
            if (take_exc) begin
                // Nested exceptions keep the original return point and BD.
                if (!status_q[1]) begin
                    epc_q    <= bus.is_in_delayslot_i ? bus.current_pc_i - 32'd4
                                                      : bus.current_pc_i;
                    cause_bd <= bus.is_in_delayslot_i;
                end
                status_q[1] <= 1'b1;
                cause_exc   <= exc_code(bus.except_type_i);
                if (bus.except_type_i == EXC_ADEL || bus.except_type_i == EXC_ADES)
                    badvaddr_q <= bus.bad_addr_i;
            end else if (is_eret) begin
                status_q[1] <= 1'b0;
            end else if (wr_en) begin
                case (bus.waddr_i)
                    REG_STATUS: begin
                        status_q[15:8] <= bus.wdata_i[15:8];
                        status_q[1:0]  <= bus.wdata_i[1:0];
                    end
                    REG_CAUSE: cause_ip[1:0] <= bus.wdata_i[9:8];
                    REG_EPC:   epc_q         <= bus.wdata_i;
                    default:   ;
                endcase
            end
        end
    end

    assign status_o    = status_q;
    assign cause_o     = {cause_bd, ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};
    assign epc_o       = epc_q;
    assign timer_int_o = ti;

    always_comb begin
        bus.rdata_o = 32'd0;
        case (bus.raddr_i)
            REG_BADVADDR: bus.rdata_o = badvaddr_q;
            REG_COUNT:    bus.rdata_o = count;
            REG_COMPARE:  bus.rdata_o = compare;
            REG_STATUS:   bus.rdata_o = status_q;
            REG_CAUSE:    bus.rdata_o = cause_o;
            REG_EPC:      bus.rdata_o = epc_q;
            REG_PRID:     bus.rdata_o = PRID_VAL;
            REG_CONFIG:   bus.rdata_o = CONFIG_VAL;
            default:      bus.rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: expectations are queued as stimulus is driven
// and compared once the DUT has produced the corresponding state.
module tb_cp0_reg;
    import cp0_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ext_int;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    cp0_reg_if bus ();

    cp0_reg dut (
        .clk         (clk),
        .rst         (rst),
        .ext_int     (ext_int),
        .bus         (bus),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .timer_int_o (timer_int_o)
    );

    always #5 clk = ~clk;

    localparam int S_STATUS = 0;
    localparam int S_CAUSE  = 1;
    localparam int S_EPC    = 2;
    localparam int S_TI     = 3;
    localparam int S_RD     = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [4:0]  addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [4:0] addr,
                              input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.addr = addr;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STATUS: return status_o;
            S_CAUSE:  return cause_o;
            S_EPC:    return epc_o;
            S_TI:     return {31'd0, timer_int_o};
            default:  return bus.rdata_o;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.sel == S_RD) begin
                bus.raddr_i = e.addr;
                #1;
            end
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.we_i    = 1'b1;
        bus.waddr_i = addr;
        bus.wdata_i = data;
        step();
        bus.we_i    = 1'b0;
    endtask

    task automatic exc(input logic [31:0] etype, input logic [31:0] pc, input logic bd,
                       input logic [31:0] bad);
        bus.is_except_i       = 1'b1;
        bus.except_type_i     = etype;
        bus.current_pc_i      = pc;
        bus.is_in_delayslot_i = bd;
        bus.bad_addr_i        = bad;
        step();
        bus.is_except_i = 1'b0;
        bus.we_i        = 1'b0;
    endtask

    initial begin
        int n;
        rst                   = 1'b1;
        ext_int               = 6'd0;
        bus.we_i              = 1'b0;
        bus.waddr_i           = 5'd0;
        bus.wdata_i           = 32'd0;
        bus.raddr_i           = 5'd0;
        bus.is_except_i       = 1'b0;
        bus.except_type_i     = 32'd0;
        bus.current_pc_i      = 32'd0;
        bus.is_in_delayslot_i = 1'b0;
        bus.bad_addr_i        = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        expect_val("rst_status", S_STATUS, 5'd0, 32'h0040_0000);
        expect_val("rst_cause",  S_CAUSE,  5'd0, 32'h0000_0000);
        expect_val("rst_epc",    S_EPC,    5'd0, 32'h0000_0000);
        expect_val("rst_count",  S_RD, REG_COUNT,  32'h0000_0000);
        expect_val("rst_prid",   S_RD, REG_PRID,   32'h0000_4220);
        expect_val("rst_config", S_RD, REG_CONFIG, 32'h0000_8000);
        drain();
        rst = 1'b0;

        // Timer: Compare=6 on the first edge out of reset, TI twelve edges later.
        mtc0(REG_COMPARE, 32'd6);
        expect_val("ti_cleared", S_TI, 5'd0, 32'd0);
        drain();
        n = 0;
        while (!timer_int_o && n <= 40) begin
            step();
            n++;
        end
        check("ti_latency", 32'(n), 32'd12);
        expect_val("ti_count", S_RD, REG_COUNT, 32'd6);
        drain();
        step();
        expect_val("ti_cause", S_CAUSE, 5'd0, 32'h4000_8000);
        drain();
        mtc0(REG_COMPARE, 32'd100);
        expect_val("ti_clear_cmp", S_TI, 5'd0, 32'd0);
        drain();
        mtc0(REG_COMPARE, 32'hFFFF_FFF0);
        expect_val("ip7_clear", S_CAUSE, 5'd0, 32'h0000_0000);
        drain();

        // Write and read EPC in the same cycle: old value until the edge.
        bus.we_i    = 1'b1;
        bus.waddr_i = REG_EPC;
        bus.wdata_i = 32'h0000_1234;
        expect_val("epc_nobypass", S_RD, REG_EPC, 32'h0000_0000);
        drain();
        step();
        bus.we_i = 1'b0;
        expect_val("epc_written", S_RD, REG_EPC, 32'h0000_1234);
        drain();

        // Count load beats the tick, then wraps within the next two cycles.
        mtc0(REG_COUNT, 32'hFFFF_FFFF);
        expect_val("count_load", S_RD, REG_COUNT, 32'hFFFF_FFFF);
        drain();
        step();
        step();
        expect_val("count_wrap", S_RD, REG_COUNT, 32'h0000_0000);
        drain();

        // AdEL in a delay slot.
        exc(EXC_ADEL, 32'hBFC0_0104, 1'b1, 32'hBFC0_0102);
        expect_val("adel_epc",    S_EPC,    5'd0, 32'hBFC0_0100);
        expect_val("adel_cause",  S_CAUSE,  5'd0, 32'h8000_0010);
        expect_val("adel_status", S_STATUS, 5'd0, 32'h0040_0002);
        expect_val("adel_bva",    S_RD, REG_BADVADDR, 32'hBFC0_0102);
        drain();

        // Nested Syscall while EXL=1, then ERET.
        exc(EXC_SYS, 32'h8000_1000, 1'b0, 32'h0000_0000);
        expect_val("sys_epc",   S_EPC,   5'd0, 32'hBFC0_0100);
        expect_val("sys_cause", S_CAUSE, 5'd0, 32'h8000_0020);
        expect_val("sys_bva",   S_RD, REG_BADVADDR, 32'hBFC0_0102);
        drain();
        exc(EXC_ERET, 32'h0000_0000, 1'b0, 32'h0000_0000);
        expect_val("eret_status", S_STATUS, 5'd0, 32'h0040_0000);
        expect_val("eret_epc",    S_EPC,    5'd0, 32'hBFC0_0100);
        expect_val("eret_cause",  S_CAUSE,  5'd0, 32'h8000_0020);
        drain();

        // Overflow colliding with an MTC0 to Status.
        bus.we_i    = 1'b1;
        bus.waddr_i = REG_STATUS;
        bus.wdata_i = 32'h0000_FF01;
        exc(EXC_OV, 32'h0000_0100, 1'b0, 32'h0000_0000);
        expect_val("ov_status", S_STATUS, 5'd0, 32'h0040_0002);
        expect_val("ov_cause",  S_CAUSE,  5'd0, 32'h0000_0030);
        expect_val("ov_epc",    S_EPC,    5'd0, 32'h0000_0100);
        drain();
        exc(EXC_ERET, 32'h0000_0000, 1'b0, 32'h0000_0000);
        mtc0(REG_STATUS, 32'h0000_FF01);
        expect_val("mtc0_status", S_STATUS, 5'd0, 32'h0040_FF01);
        drain();

        // Interrupt type maps to ExcCode 0 and leaves BadVAddr alone.
        exc(EXC_INT, 32'h0000_0200, 1'b0, 32'h0000_0055);
        expect_val("int_epc",    S_EPC,    5'd0, 32'h0000_0200);
        expect_val("int_cause",  S_CAUSE,  5'd0, 32'h0000_0000);
        expect_val("int_status", S_STATUS, 5'd0, 32'h0040_FF03);
        expect_val("int_bva",    S_RD, REG_BADVADDR, 32'hBFC0_0102);
        drain();
        exc(EXC_ERET, 32'h0000_0000, 1'b0, 32'h0000_0000);
        expect_val("eret2_status", S_STATUS, 5'd0, 32'h0040_FF01);
        drain();

        // Hardware and software interrupt pending bits.
        ext_int = 6'b000010;
        step();
        expect_val("hw_ip3", S_CAUSE, 5'd0, 32'h0000_0800);
        drain();
        mtc0(REG_CAUSE, 32'h0000_0300);
        expect_val("sw_ip",    S_CAUSE, 5'd0, 32'h0000_0B00);
        expect_val("sw_ip_rd", S_RD, REG_CAUSE, 32'h0000_0B00);
        drain();
        mtc0(5'd3, 32'hFFFF_FFFF);
        expect_val("unimpl_rd", S_RD, 5'd3, 32'h0000_0000);
        drain();

        // Asynchronous reset in the middle of an exception commit.
        bus.is_except_i       = 1'b1;
        bus.except_type_i     = EXC_ADEL;
        bus.current_pc_i      = 32'h1234_5678;
        bus.is_in_delayslot_i = 1'b1;
        bus.bad_addr_i        = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        #1;
        expect_val("arst_status", S_STATUS, 5'd0, 32'h0040_0000);
        expect_val("arst_cause",  S_CAUSE,  5'd0, 32'h0000_0000);
        expect_val("arst_epc",    S_EPC,    5'd0, 32'h0000_0000);
        expect_val("arst_bva",    S_RD, REG_BADVADDR, 32'h0000_0000);
        expect_val("arst_count",  S_RD, REG_COUNT,    32'h0000_0000);
        drain();
        bus.is_except_i = 1'b0;
        step();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
